// File: rtl/imem_loader_pkg.sv
// Shared types and constants for the boot-time instruction-memory loader.
package loader_pkg;
    typedef enum logic [2:0] {HDR0, HDR1, DATA, DONE, ERR} loader_state_t;

    localparam int HDR_BYTES      = 2;
    localparam int BYTES_PER_WORD = 4;
    localparam int CNT_W          = 8 * HDR_BYTES;
endpackage

// File: rtl/imem_loader_if.sv
// Byte-stream input and instruction-memory write port of the loader.
interface imem_loader_if;
    logic        rx_valid;
    logic [7:0]  rx_data;
    logic        rx_ready;
    logic        InstrWrite;
    logic [31:0] WriteInst;
    logic [31:0] WriteAdress;

    modport slave  (input rx_valid, rx_data, output rx_ready, InstrWrite, WriteInst, WriteAdress);
    modport master (output rx_valid, rx_data, input rx_ready, InstrWrite, WriteInst, WriteAdress);
endinterface

// File: rtl/imem_loader_byte_assembler.sv
// Little-endian 4-byte word assembler; word is valid combinationally with word_done.
module byte_assembler
    import loader_pkg::*;
(
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        shift_en,
    input  logic                        clear,
    input  logic [7:0]                  byte_i,
    output logic [8*BYTES_PER_WORD-1:0] word,
    output logic                        word_done
);
    localparam int IW = $clog2(BYTES_PER_WORD);

    logic [8*(BYTES_PER_WORD-1)-1:0] sr_q, sr_d;
    logic [IW-1:0]                   idx_q, idx_d;

    // Earlier bytes drift toward the low end so the first byte lands in [7:0].
    assign word      = {byte_i, sr_q};
    assign word_done = shift_en && !clear && (idx_q == IW'(BYTES_PER_WORD - 1));

    always_comb begin
        sr_d  = sr_q;
        idx_d = idx_q;
        if (clear) begin
            idx_d = '0;
        end else if (shift_en) begin
            sr_d  = {byte_i, sr_q[8*(BYTES_PER_WORD-1)-1:8]};
            idx_d = idx_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sr_q  <= '0;
            idx_q <= '0;
        end else begin
            sr_q  <= sr_d;
            idx_q <= idx_d;
        end
    end
endmodule

// File: rtl/imem_loader.sv
// Length-prefixed byte-stream loader that writes instruction memory and holds the core in reset until done.
module imem_loader
    import loader_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
    parameter int          MAX_WORDS = 256
) (
    input  logic          clk,
    input  logic          reset,
    imem_loader_if.slave  bus,
    output logic          core_reset,
    output logic          done,
    output logic          error
);
    localparam logic [CNT_W-1:0] MAX_N = CNT_W'(MAX_WORDS);

    loader_state_t     state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d, idx_q, idx_d, hdr_n;
    logic [31:0]       winst_q, winst_d, waddr_q, waddr_d;
    logic              rdy_q, rdy_d, iw_q, iw_d;
    logic              crst_q, done_q, err_q;
    logic              xfer, asm_en, asm_clr, word_done;
    logic [31:0]       word;

    assign xfer  = bus.rx_valid & rdy_q;
    assign hdr_n = {bus.rx_data, cnt_q[7:0]};

    byte_assembler u_asm (
        .clk       (clk),
        .reset     (reset),
        .shift_en  (asm_en),
        .clear     (asm_clr),
        .byte_i    (bus.rx_data),
        .word      (word),
        .word_done (word_done)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        winst_d = winst_q;
        waddr_d = waddr_q;
        iw_d    = 1'b0;
        asm_en  = 1'b0;
        asm_clr = 1'b0;
        case (state_q)
            HDR0: if (xfer) begin
                cnt_d[7:0] = bus.rx_data;
                state_d    = HDR1;
            end
            HDR1: if (xfer) begin
                cnt_d   = hdr_n;
                idx_d   = '0;
                asm_clr = 1'b1;
                if (hdr_n == '0)        state_d = DONE;
                else if (hdr_n > MAX_N) state_d = ERR;
                else                    state_d = DATA;
            end
            DATA: if (xfer) begin
                asm_en = 1'b1;
                if (word_done) begin
                    winst_d = word;
                    waddr_d = BASE_ADDR + (32'(idx_q) << 2);
                    iw_d    = 1'b1;
                    idx_d   = idx_q + 1'b1;
                    if (idx_q == cnt_q - 1'b1) state_d = DONE;
                end
            end
            default: ;
        endcase
        // Ready tracks the next state so it drops in the final write-pulse cycle.
        rdy_d = (state_d == HDR0) || (state_d == HDR1) || (state_d == DATA);
    end

    // Status lags state by one edge so the last write commits before the core leaves reset.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= HDR0;
            cnt_q   <= '0;
            idx_q   <= '0;
            winst_q <= '0;
            waddr_q <= BASE_ADDR;
            rdy_q   <= 1'b0;
            iw_q    <= 1'b0;
            crst_q  <= 1'b1;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            winst_q <= winst_d;
            waddr_q <= waddr_d;
            rdy_q   <= rdy_d;
            iw_q    <= iw_d;
            crst_q  <= (state_q != DONE);
            done_q  <= (state_q == DONE);
            err_q   <= (state_q == ERR);
        end
    end

    assign bus.rx_ready    = rdy_q;
    assign bus.InstrWrite  = iw_q;
    assign bus.WriteInst   = winst_q;
    assign bus.WriteAdress = waddr_q;
    assign core_reset      = crst_q;
    assign done            = done_q;
    assign error           = err_q;
endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: two instances (default base and a wrapping base) fed the same stream.
module tb_imem_loader;
    logic clk = 1'b0;
    logic reset = 1'b0;
    logic crst0, done0, err0, crst1, done1, err1;
    int   n_vec = 0, n_err = 0;
    int   b2b = 0;
    logic prev0 = 1'b0, prev1 = 1'b0;
    logic [31:0] qa0[$], qd0[$], qa1[$], qd1[$];

    imem_loader_if bus0();
    imem_loader_if bus1();

    imem_loader u_dut0 (
        .clk(clk), .reset(reset), .bus(bus0.slave),
        .core_reset(crst0), .done(done0), .error(err0)
    );
    imem_loader #(.BASE_ADDR(32'hFFFF_FFF8)) u_dut1 (
        .clk(clk), .reset(reset), .bus(bus1.slave),
        .core_reset(crst1), .done(done1), .error(err1)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (bus0.InstrWrite) begin qa0.push_back(bus0.WriteAdress); qd0.push_back(bus0.WriteInst); end
        if (bus1.InstrWrite) begin qa1.push_back(bus1.WriteAdress); qd1.push_back(bus1.WriteInst); end
        if ((bus0.InstrWrite && prev0) || (bus1.InstrWrite && prev1)) b2b++;
        prev0 = bus0.InstrWrite;
        prev1 = bus1.InstrWrite;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h exp %h", tag, got, exp);
        end
    endtask

    task automatic drive(input logic v, input logic [7:0] b);
        bus0.rx_valid = v; bus0.rx_data = b;
        bus1.rx_valid = v; bus1.rx_data = b;
    endtask

    // Called at a negedge; returns at the negedge after the accepting posedge.
    task automatic send(input logic [7:0] b);
        int t = 0;
        drive(1'b1, b);
        while (!bus0.rx_ready && t < 50) begin @(negedge clk); t++; end
        if (t >= 50) chk("rdy_timeout", 32'd0, 32'd1);
        @(negedge clk);
        drive(1'b0, 8'h00);
    endtask

    task automatic idle(input int n);
        drive(1'b0, 8'h00);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_reset(input string tag);
        @(negedge clk);
        reset = 1'b0;
        drive(1'b0, 8'h00);
        #1;
        chk({tag, "_rdy"},   {31'd0, bus0.rx_ready},   32'd0);
        chk({tag, "_iw"},    {31'd0, bus0.InstrWrite}, 32'd0);
        chk({tag, "_inst"},  bus0.WriteInst,           32'd0);
        chk({tag, "_addr0"}, bus0.WriteAdress,         32'h0000_0000);
        chk({tag, "_addr1"}, bus1.WriteAdress,         32'hFFFF_FFF8);
        chk({tag, "_stat"},  {29'd0, crst0, done0, err0}, 32'b100);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        chk({tag, "_rdy_up"}, {31'd0, bus0.rx_ready}, 32'd1);
        qa0.delete(); qd0.delete(); qa1.delete(); qd1.delete();
    endtask

    function automatic logic [31:0] qget(input logic [31:0] q[$], input int i);
        return (i < q.size()) ? q[i] : 32'hxxxx_xxxx;
    endfunction

    initial begin
        logic [7:0] img[$];
        drive(1'b0, 8'h00);

        // N=2 contiguous image
        do_reset("r1");
        img = '{8'h02, 8'h00, 8'h13, 8'h05, 8'h50, 8'h00, 8'h93, 8'h05, 8'hF0, 8'h7F};
        foreach (img[i]) begin bus0.rx_valid = 1'b1; send(img[i]); end
        chk("t1_pulse_iw",   {31'd0, bus0.InstrWrite}, 32'd1);
        chk("t1_pulse_rdy",  {31'd0, bus0.rx_ready},   32'd0);
        chk("t1_pulse_stat", {30'd0, crst0, done0},    32'b10);
        @(negedge clk);
        chk("t1_post_iw",    {31'd0, bus0.InstrWrite}, 32'd0);
        chk("t1_post_stat",  {30'd0, crst0, done0},    32'b01);
        chk("t1_n",  qd0.size(),   32'd2);
        chk("t1_d0", qget(qd0, 0), 32'h0050_0513);
        chk("t1_a0", qget(qa0, 0), 32'h0000_0000);
        chk("t1_d1", qget(qd0, 1), 32'h7FF0_0593);
        chk("t1_a1", qget(qa0, 1), 32'h0000_0004);
        drive(1'b1, 8'hAA);
        repeat (4) @(negedge clk);
        chk("t1_extra_rdy", {31'd0, bus0.rx_ready}, 32'd0);
        chk("t1_extra_n",   qd0.size(),             32'd2);
        chk("t1_hold_inst", bus0.WriteInst,         32'h7FF0_0593);

        // N=0 header
        do_reset("r2");
        send(8'h00); send(8'h00);
        chk("t2_pre_done", {30'd0, crst0, done0}, 32'b10);
        @(negedge clk);
        chk("t2_stat", {29'd0, crst0, done0, err0}, 32'b010);
        chk("t2_rdy",  {31'd0, bus0.rx_ready}, 32'd0);
        idle(3);
        chk("t2_n", qd0.size(), 32'd0);

        // N=257 rejected
        do_reset("r3");
        send(8'h01); send(8'h01);
        @(negedge clk);
        chk("t3_stat", {29'd0, crst0, done0, err0}, 32'b101);
        chk("t3_rdy",  {31'd0, bus0.rx_ready}, 32'd0);
        drive(1'b1, 8'h55);
        repeat (6) @(negedge clk);
        chk("t3_n",    qd0.size(), 32'd0);
        chk("t3_stay", {29'd0, crst0, done0, err0}, 32'b101);

        // N=1 with random valid gaps
        do_reset("r4");
        img = '{8'h01, 8'h00, 8'hEF, 8'hBE, 8'hAD, 8'hDE};
        foreach (img[i]) begin idle($urandom_range(0, 5)); send(img[i]); end
        idle(2);
        chk("t4_n",    qd0.size(),   32'd1);
        chk("t4_d0",   qget(qd0, 0), 32'hDEAD_BEEF);
        chk("t4_a0",   qget(qa0, 0), 32'h0000_0000);
        chk("t4_done", {30'd0, crst0, done0}, 32'b01);

        // Reset mid-load, then a fresh N=1 image
        do_reset("r5");
        img = '{8'h03, 8'h00, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06};
        foreach (img[i]) send(img[i]);
        chk("t5_partial_n", qd0.size(), 32'd1);
        do_reset("r5b");
        img = '{8'h01, 8'h00, 8'h78, 8'h56, 8'h34, 8'h12};
        foreach (img[i]) send(img[i]);
        idle(2);
        chk("t5_n",    qd0.size(),   32'd1);
        chk("t5_d0",   qget(qd0, 0), 32'h1234_5678);
        chk("t5_a0",   qget(qa0, 0), 32'h0000_0000);
        chk("t5_done", {30'd0, crst0, done0}, 32'b01);

        // Address wrap on the high-base instance
        do_reset("r6");
        img = '{8'h03, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88,
                8'h99, 8'hAA, 8'hBB, 8'hCC};
        foreach (img[i]) send(img[i]);
        idle(2);
        chk("t6_n",  qd1.size(),   32'd3);
        chk("t6_a0", qget(qa1, 0), 32'hFFFF_FFF8);
        chk("t6_a1", qget(qa1, 1), 32'hFFFF_FFFC);
        chk("t6_a2", qget(qa1, 2), 32'h0000_0000);
        chk("t6_d0", qget(qd1, 0), 32'h4433_2211);
        chk("t6_d2", qget(qd1, 2), 32'hCCBB_AA99);
        chk("t6_done1", {30'd0, crst1, done1}, 32'b01);

        chk("b2b_pulses", b2b, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/imem_loader.md
# imem_loader

Boot-time program loader that sits upstream of the pipelined core's instruction-memory write port. It receives a length-prefixed little-endian byte stream over a valid/ready interface and assembles it into 32-bit instruction words. It drives `InstrWrite`/`WriteInst`/`WriteAdress` into the core top, holding the core in reset until the whole image is written. On a malformed header it refuses the image and keeps the core in reset.

## Interface

- `BASE_ADDR`, default 32'h0000_0000: byte address of the first instruction word.
- `MAX_WORDS`, default 256: largest accepted word count, legal range 1..65535.
- `clk`  in  1  single clock; all state updates on the rising edge.
- `reset`  in  1  asynchronous, active-low; 0 forces every register to its reset value immediately.
- `rx_valid`  in  1  byte on `rx_data` is valid.
- `rx_data`  in  8  stream byte.
- `rx_ready`  out  1  loader accepts a byte this cycle; a transfer occurs when `rx_valid & rx_ready`.
- `InstrWrite`  out  1  one-cycle instruction-memory write strobe to the core top.
- `WriteInst`  out  32  instruction word to write.
- `WriteAdress`  out  32  byte address of that word.
- `core_reset`  out  1  active-high reset to the core top; 1 until the load completes.
- `done`  out  1  sticky; image fully written.
- `error`  out  1  sticky; header rejected.

## Operation

- Stream format: 2 header bytes giving word count N (16-bit, LSB first), then N×4 data bytes. Each word is little-endian: the first byte goes to `WriteInst[7:0]`.
- States: HDR0, HDR1, DATA, DONE, ERR. The loader enters HDR0 when reset releases.
- HDR0: a transfer stores count[7:0], then go to HDR1.
- HDR1: a transfer stores count[15:8], then:
  - N == 0: go to DONE.
  - N > MAX_WORDS: go to ERR.
  - Otherwise: go to DATA with the word index and byte index cleared.
- DATA: each transfer shifts the byte into the 4-byte assembler.
  - On the 4th byte, register `WriteInst` = assembled word and `WriteAdress` = BASE_ADDR + 4×index, pulse `InstrWrite`, and increment the index.
  - When the written word is index N−1, go to DONE.
- DONE: `rx_ready`=0, `core_reset`=0, `done`=1. The loader stays here until reset; extra input bytes are ignored and not consumed.
- ERR: `rx_ready`=0, `core_reset`=1, `error`=1. The loader stays here until reset.
- Address arithmetic is 32-bit modulo 2^32; BASE_ADDR must be word-aligned. The word index is 16 bits wide.
- Bytes arriving with `rx_valid` gaps are simply waited for. The byte index is held across gaps and never resets mid-word.
- Reset asserted mid-load: all state is discarded and the partial image is left in memory. The next load restarts at HDR0 and rewrites from BASE_ADDR.

## Timing

- Reset values:
  - `rx_ready`=0, `InstrWrite`=0, `WriteInst`=0, `WriteAdress`=BASE_ADDR.
  - `core_reset`=1, `done`=0, `error`=0.
- All outputs are registered.
- `rx_ready` rises on the first rising edge after reset deasserts and stays 1 through HDR0, HDR1 and DATA. The loader sustains one byte per cycle.
- `InstrWrite` is high for exactly the one cycle after the edge that accepted a word's 4th byte. `WriteInst` and `WriteAdress` hold their values until the next write.
- `InstrWrite` never pulses on two consecutive cycles. Minimum spacing between pulses is 4 cycles.
- On the final word, DONE is entered at that same edge. `rx_ready` is 0 in the pulse cycle. `core_reset` falls and `done` rises on the following edge, one cycle after `InstrWrite` is high, so the memory write commits before the core leaves reset.
- When N == 0: `done` rises and `core_reset` falls on the edge after HDR1 acceptance, with no `InstrWrite`.
- Load latency with no gaps: 2 + 4N cycles from the first accepted byte to the last `InstrWrite`, plus 1 cycle to `core_reset` low.

## Structure

- Shared package `loader_pkg` holds:
  - the `loader_state_t` enum (HDR0, HDR1, DATA, DONE, ERR);
  - `HDR_BYTES`=2, `BYTES_PER_WORD`=4;
  - the count-width constant, 16.
- One sub-module, `byte_assembler`: 4-byte LE shift register with a 2-bit byte index.
  - Inputs: `shift_en`, `clear`.
  - Outputs: `word`, `word_done`.
- Counter, address generation and FSM live in `imem_loader`.

## Test plan

- N=2, bytes 13 05 50 00 93 05 F0 7F contiguous:
  - pulse 1: `WriteInst`=32'h0050_0513 at BASE_ADDR+0;
  - pulse 2: 32'h7FF0_0593 at BASE_ADDR+4;
  - `core_reset` low and `done` high one cycle after the 2nd pulse.
- Header 00 00: no `InstrWrite`; `done`=1 and `core_reset`=0 on the edge after HDR1; `rx_ready`=0 afterwards.
- Header 01 01 (N=257 > 256): `error`=1, `core_reset` stays 1, `rx_ready`=0, no `InstrWrite` ever.
- N=1 with random 0–5 cycle `rx_valid` gaps between bytes: a single pulse with the correct word. No byte is dropped or duplicated, and the byte index is held across gaps.
- Assert `reset` after 6 data bytes of an N=3 load, then release and send a fresh N=1 image: outputs return to reset values; exactly one pulse at BASE_ADDR with the new word.
- BASE_ADDR=32'hFFFF_FFF8, N=3: addresses FFFF_FFF8, FFFF_FFFC, 0000_0000 (modulo wrap).
